tap_window_reader: RTL and testbench

Sample-window store for the FIR datapath. Accepts one new input word per accepted handshake into a circular buffer of `size` words. After each accept it streams the whole window out, newest first, one word per valid/ready beat, to the MAC sequencer. This is the read-out counterpart of the tapped delay line: a write-once, read-`size`-times window.

---
 rtl/tap_window_pkg.sv | 11 +
 rtl/wrap_counter.sv | 39 +++
 rtl/tap_window_reader.sv | 124 ++++++++++++
 tb/tb_tap_window_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tap_window_pkg.sv
// rtl/tap_window_pkg.sv - shared state encodings and pointer sizing for the tap window reader
package tap_window_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-N up/down counter with load and clear, for buffer pointers
module wrap_counter
    import tap_window_pkg::*;
#(
    parameter int modulus = 8,
    parameter int width   = ptr_width(modulus)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [width-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [width-1:0] o_count
);

    localparam logic [width-1:0] MAX_VAL = width'(modulus - 1);

    logic [width-1:0] r_count;

    // Wrap is an explicit compare so non-power-of-two moduli stay in range.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !i_dec) begin
            r_count <= (r_count == MAX_VAL) ? '0 : r_count + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_count <= (r_count == '0) ? MAX_VAL : r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tap_window_reader.sv
// rtl/tap_window_reader.sv - circular sample window streamed newest-first per accepted sample; optional TAP_WINDOW_FLUSH_EN adds a flush port
module tap_window_reader
    import tap_window_pkg::*;
#(
    parameter int size      = 8,
    parameter int bit_width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef TAP_WINDOW_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     sample_valid,
    input  logic [bit_width-1:0]     sample_in,
    output logic                     sample_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bit_width-1:0]     out_data,
    output logic [$clog2(size)-1:0]  out_index,
    output logic                     out_last,
    output logic                     done
);

    localparam int PW = ptr_width(size);
    localparam logic [PW-1:0] LAST_IDX = PW'(size - 1);

    logic [bit_width-1:0] r_mem [size];
    logic [0:0]           r_state;
    logic [PW-1:0]        r_index;
    logic                 r_done;

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic          w_flush;
    logic          w_streaming;
    logic          w_accept;
    logic          w_beat;
    logic          w_last;

`ifdef TAP_WINDOW_FLUSH_EN
    assign w_flush = flush && (r_state == ST_IDLE);
`else
    assign w_flush = 1'b0;
`endif

    assign w_streaming  = (r_state == ST_STREAM);
    assign sample_ready = !w_streaming && !w_flush;
    assign w_accept     = sample_ready && sample_valid;
    assign w_beat       = w_streaming && out_ready;
    assign w_last       = w_streaming && (r_index == LAST_IDX);

    assign out_valid = w_streaming;
    assign out_data  = w_streaming ? r_mem[w_rd_ptr] : '0;
    assign out_index = r_index;
    assign out_last  = w_last;
    assign done      = r_done;

    wrap_counter #(.modulus(size), .width(PW)) u_wr_ptr (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clear    (w_flush),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_accept),
        .i_dec      (1'b0),
        .o_count    (w_wr_ptr)
    );

    // Read pointer starts on the slot just written, then walks backwards to older samples.
    wrap_counter #(.modulus(size), .width(PW)) u_rd_ptr (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clear    (1'b0),
        .i_load     (w_accept),
        .i_load_val (w_wr_ptr),
        .i_inc      (1'b0),
        .i_dec      (w_beat),
        .o_count    (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < size; i++) r_mem[i] <= '0;
        end else if (w_flush) begin
            for (int i = 0; i < size; i++) r_mem[i] <= '0;
        end else if (w_accept) begin
            r_mem[w_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_STREAM;
                        r_index <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_index <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_window_reader.sv
// tb/tb_tap_window_reader.sv - directed-vector bench for tap_window_reader at size=4, bit_width=8
module tb_tap_window_reader;

    localparam int SIZE = 4;
    localparam int BW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_valid = 1'b0;
    logic [BW-1:0] sample_in = '0;
    logic          out_ready = 1'b1;
`ifdef TAP_WINDOW_FLUSH_EN
    logic          flush = 1'b0;
`endif
    logic          sample_ready;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [1:0]    out_index;
    logic          out_last;
    logic          done;

    int n_vec  = 0;
    int n_miss = 0;

    tap_window_reader #(.size(SIZE), .bit_width(BW)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef TAP_WINDOW_FLUSH_EN
        .flush        (flush),
`endif
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [7:0] exp_data);
        check_vec($sformatf("%s_valid%0d", tag, idx), 32'(out_valid), 32'd1);
        check_vec($sformatf("%s_index%0d", tag, idx), 32'(out_index), 32'(idx));
        check_vec($sformatf("%s_data%0d", tag, idx), 32'(out_data), 32'(exp_data));
        check_vec($sformatf("%s_last%0d", tag, idx), 32'(out_last), (idx == SIZE - 1) ? 32'd1 : 32'd0);
        check_vec($sformatf("%s_sready%0d", tag, idx), 32'(sample_ready), 32'd0);
        check_vec($sformatf("%s_done%0d", tag, idx), 32'(done), 32'd0);
    endtask

    // Called just after a falling edge while idle; returns just after the accepting rising edge.
    task automatic push(input logic [7:0] d);
        check_vec("push_ready", 32'(sample_ready), 32'd1);
        sample_valid = 1'b1;
        sample_in    = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // exp packs the window newest-first in the top byte; returns at the falling edge of the done cycle.
    task automatic read_window(input string tag, input logic [31:0] exp, input int stall_at, input int stall_n);
        logic [7:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            @(negedge clk);
            b = exp[8*(SIZE-1-i) +: 8];
            check_beat(tag, i, b);
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    check_beat({tag, "_stall"}, i, b);
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check_vec({tag, "_done"}, 32'(done), 32'd1);
        check_vec({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check_vec({tag, "_end_sready"}, 32'(sample_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        #12;
        check_vec("rst_sready", 32'(sample_ready), 32'd1);
        check_vec("rst_valid", 32'(out_valid), 32'd0);
        check_vec("rst_data", 32'(out_data), 32'd0);
        check_vec("rst_index", 32'(out_index), 32'd0);
        check_vec("rst_last", 32'(out_last), 32'd0);
        check_vec("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        push(8'h11);
        read_window("w11", 32'h11000000, -1, 0);
        @(negedge clk);
        check_vec("w11_done_clear", 32'(done), 32'd0);

        push(8'h22); read_window("w22", 32'h22110000, -1, 0);
        push(8'h33); read_window("w33", 32'h33221100, -1, 0);
        push(8'h44); read_window("w44", 32'h44332211, -1, 0);
        push(8'h55); read_window("w55", 32'h55443322, -1, 0);

        push(8'h66); read_window("bp", 32'h66554433, 1, 3);

        push(8'h77);
        sample_valid = 1'b1;
        sample_in    = 8'h99;
        read_window("ign", 32'h77665544, -1, 0);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        read_window("w99", 32'h99776655, -1, 0);

        push(8'h5a);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_vec("mid_index", 32'(out_index), 32'd2);
        rst = 1'b0;
        #1;
        check_vec("mid_rst_valid", 32'(out_valid), 32'd0);
        check_vec("mid_rst_sready", 32'(sample_ready), 32'd1);
        check_vec("mid_rst_index", 32'(out_index), 32'd0);
        check_vec("mid_rst_data", 32'(out_data), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_vec("mid_rst_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_vec("post_rst_done", 32'(done), 32'd0);
        check_vec("post_rst_valid", 32'(out_valid), 32'd0);
        push(8'h01);
        read_window("w01", 32'h01000000, -1, 0);

`ifdef TAP_WINDOW_FLUSH_EN
        push(8'h01); read_window("f1", 32'h01010000, -1, 0);
        push(8'h02); read_window("f2", 32'h02010100, -1, 0);
        push(8'h03); read_window("f3", 32'h03020101, -1, 0);
        push(8'h04); read_window("f4", 32'h04030201, -1, 0);
        flush        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 8'h07;
        #1;
        check_vec("flush_sready", 32'(sample_ready), 32'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        check_vec("flush_no_accept", 32'(out_valid), 32'd0);
        push(8'h08);
        read_window("w08", 32'h08000000, -1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
